// File: rtl/ten_half_ctrl.sv
// rtl/ten_half_ctrl.sv - ten-point-half round sequencer: draws cards, scores hands, plays dealer, reports outcome
module ten_half_ctrl #(
    parameter int DEALER_STAND = 16,
    parameter int MAX_CARDS    = 5,
    parameter int DECK_SIZE    = 52
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hit,
    input  logic       stand,
    output logic       pip,
    input  logic [3:0] number,
    output logic [5:0] player_score,
    output logic [5:0] dealer_score,
    output logic [2:0] player_cards,
    output logic [2:0] dealer_cards,
    output logic       busy,
    output logic       result_valid,
    output logic [1:0] result,
    output logic       deck_empty
);

    typedef enum logic [2:0] {S_IDLE, S_DRAW, S_LOAD, S_PLAY, S_DEAL, S_DONE} state_t;
    typedef enum logic [1:0] {R_INIT_P, R_INIT_D, R_HIT, R_DEALER} ret_t;
    typedef enum logic {T_PLAYER, T_DEALER} target_t;

    localparam logic [5:0] DECK_MAX   = 6'(DECK_SIZE);
    localparam logic [5:0] STAND_HP   = 6'(DEALER_STAND);
    localparam logic [2:0] CARD_MAX   = 3'(MAX_CARDS);
    localparam logic [5:0] BUST_LIMIT = 6'd21;

    localparam logic [1:0] RES_ABORT  = 2'b00;
    localparam logic [1:0] RES_PLAYER = 2'b01;
    localparam logic [1:0] RES_DEALER = 2'b10;
    localparam logic [1:0] RES_TIE    = 2'b11;

    state_t     state, state_d;
    ret_t       ret, ret_d;
    target_t    target, target_d;
    logic [5:0] deck_cnt, deck_cnt_d;
    logic [5:0] player_score_d, dealer_score_d;
    logic [2:0] player_cards_d, dealer_cards_d;
    logic       pip_d, busy_d, result_valid_d, deck_empty_d;
    logic [1:0] result_d;

    logic [5:0] card_val;
    logic [5:0] player_sum, dealer_sum;
    logic [2:0] player_cnt, dealer_cnt;

    // Face cards are worth half a point; out-of-range codes count as a card worth nothing.
    function automatic logic [5:0] card_value(input logic [3:0] n);
        if (n inside {[4'd1:4'd10]}) begin
            return {1'b0, n, 1'b0};
        end else if (n inside {[4'd11:4'd13]}) begin
            return 6'd1;
        end else begin
            return 6'd0;
        end
    endfunction

    assign card_val   = card_value(number);
    assign player_sum = player_score + card_val;
    assign dealer_sum = dealer_score + card_val;
    assign player_cnt = player_cards + 3'd1;
    assign dealer_cnt = dealer_cards + 3'd1;

    always_comb begin
        state_d        = state;
        ret_d          = ret;
        target_d       = target;
        deck_cnt_d     = deck_cnt;
        player_score_d = player_score;
        dealer_score_d = dealer_score;
        player_cards_d = player_cards;
        dealer_cards_d = dealer_cards;
        result_valid_d = result_valid;
        result_d       = result;
        deck_empty_d   = deck_empty;

        case (state)
            S_IDLE, S_DONE: begin
                if (start && !deck_empty) begin
                    player_score_d = 6'd0;
                    dealer_score_d = 6'd0;
                    player_cards_d = 3'd0;
                    dealer_cards_d = 3'd0;
                    result_valid_d = 1'b0;
                    result_d       = RES_ABORT;
                    target_d       = T_PLAYER;
                    ret_d          = R_INIT_P;
                    state_d        = S_DRAW;
                end
            end
            S_DRAW: begin
                if (deck_cnt == DECK_MAX) begin
                    deck_empty_d   = 1'b1;
                    result_d       = RES_ABORT;
                    result_valid_d = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    deck_cnt_d = deck_cnt + 6'd1;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (target == T_PLAYER) begin
                    player_score_d = player_sum;
                    player_cards_d = player_cnt;
                end else begin
                    dealer_score_d = dealer_sum;
                    dealer_cards_d = dealer_cnt;
                end
                case (ret)
                    R_INIT_P: begin
                        target_d = T_DEALER;
                        ret_d    = R_INIT_D;
                        state_d  = S_DRAW;
                    end
                    R_INIT_D: state_d = S_PLAY;
                    R_HIT: begin
                        if (player_sum > BUST_LIMIT) begin
                            result_d       = RES_DEALER;
                            result_valid_d = 1'b1;
                            state_d        = S_DONE;
                        end else if (player_cnt == CARD_MAX) begin
                            result_d       = RES_PLAYER;
                            result_valid_d = 1'b1;
                            state_d        = S_DONE;
                        end else begin
                            state_d = S_PLAY;
                        end
                    end
                    default: begin
                        if (dealer_sum > BUST_LIMIT) begin
                            result_d       = RES_PLAYER;
                            result_valid_d = 1'b1;
                            state_d        = S_DONE;
                        end else if (dealer_cnt == CARD_MAX) begin
                            result_d       = RES_DEALER;
                            result_valid_d = 1'b1;
                            state_d        = S_DONE;
                        end else begin
                            state_d = S_DEAL;
                        end
                    end
                endcase
            end
            S_PLAY: begin
                // stand has priority over a simultaneous hit
                if (stand) begin
                    state_d = S_DEAL;
                end else if (hit) begin
                    target_d = T_PLAYER;
                    ret_d    = R_HIT;
                    state_d  = S_DRAW;
                end
            end
            S_DEAL: begin
                if (dealer_score < STAND_HP) begin
                    target_d = T_DEALER;
                    ret_d    = R_DEALER;
                    state_d  = S_DRAW;
                end else begin
                    if (player_score > dealer_score) begin
                        result_d = RES_PLAYER;
                    end else if (player_score < dealer_score) begin
                        result_d = RES_DEALER;
                    end else begin
                        result_d = RES_TIE;
                    end
                    result_valid_d = 1'b1;
                    state_d        = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // pip is registered, so it is decided on entry to DRAW; an exhausted deck gets no strobe
        pip_d  = (state_d == S_DRAW) && (deck_cnt_d != DECK_MAX);
        busy_d = (state_d == S_DRAW) || (state_d == S_LOAD) ||
                 (state_d == S_PLAY) || (state_d == S_DEAL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            ret          <= R_INIT_P;
            target       <= T_PLAYER;
            deck_cnt     <= 6'd0;
            player_score <= 6'd0;
            dealer_score <= 6'd0;
            player_cards <= 3'd0;
            dealer_cards <= 3'd0;
            pip          <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= 2'b00;
            deck_empty   <= 1'b0;
        end else begin
            state        <= state_d;
            ret          <= ret_d;
            target       <= target_d;
            deck_cnt     <= deck_cnt_d;
            player_score <= player_score_d;
            dealer_score <= dealer_score_d;
            player_cards <= player_cards_d;
            dealer_cards <= dealer_cards_d;
            pip          <= pip_d;
            busy         <= busy_d;
            result_valid <= result_valid_d;
            result       <= result_d;
            deck_empty   <= deck_empty_d;
        end
    end

endmodule

// File: tb/tb_ten_half_ctrl.sv
// tb/tb_ten_half_ctrl.sv - directed and random rounds checked against a hand-level game model
module tb_ten_half_ctrl;

    localparam int DSZ = 52;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic       stand = 1'b0;
    logic       pip;
    logic [3:0] number = 4'd0;
    logic [5:0] player_score, dealer_score;
    logic [2:0] player_cards, dealer_cards;
    logic       busy, result_valid, deck_empty;
    logic [1:0] result;

    ten_half_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .stand(stand),
        .pip(pip), .number(number),
        .player_score(player_score), .dealer_score(dealer_score),
        .player_cards(player_cards), .dealer_cards(dealer_cards),
        .busy(busy), .result_valid(result_valid), .result(result),
        .deck_empty(deck_empty)
    );

    always #5 clk = ~clk;

    // deck LUT stand-in: next scripted card appears the cycle after pip
    int deck_q[$];
    always @(posedge clk) begin
        if (pip) number <= (deck_q.size() > 0) ? 4'(deck_q.pop_front()) : 4'd0;
    end

    int total = 0;
    int bad = 0;

    int m_deck[$];
    int acts_q[$];
    int m_consumed = 0;
    bit m_empty = 0;
    int ps, pc, ds, dc;

    function automatic int half_val(input int n);
        if (n >= 1 && n <= 10) return 2 * n;
        if (n >= 11 && n <= 13) return 1;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_card(input int n);
        deck_q.push_back(n);
        m_deck.push_back(n);
    endtask

    // entered in the DRAW cycle; returns in the cycle after LOAD (or in DONE on abort)
    task automatic draw_card(output bit ok, output int v);
        int n;
        if (m_consumed == DSZ) begin
            chk("abort_no_pip", pip, 0);
            tick();
            chk("abort_valid", result_valid, 1);
            chk("abort_result", result, 0);
            chk("abort_empty", deck_empty, 1);
            chk("abort_busy", busy, 0);
            m_empty = 1;
            ok = 0;
            v = 0;
        end else begin
            chk("pip_draw", pip, 1);
            m_consumed++;
            n = (m_deck.size() > 0) ? m_deck.pop_front() : 0;
            v = half_val(n);
            tick();
            chk("pip_load", pip, 0);
            chk("busy_load", busy, 1);
            tick();
            ok = 1;
        end
    endtask

    task automatic finish_chk(input int exp_res);
        chk("done_valid", result_valid, 1);
        chk("done_result", result, exp_res);
        chk("done_busy", busy, 0);
        chk("done_pscore", player_score, ps);
        chk("done_dscore", dealer_score, ds);
        chk("done_pcards", player_cards, pc);
        chk("done_dcards", dealer_cards, dc);
    endtask

    task automatic round();
        bit ok;
        int v, act, r;
        ps = 0; pc = 0; ds = 0; dc = 0;
        start = 1; tick(); start = 0;
        chk("busy_c1", busy, 1);
        chk("valid_cleared", result_valid, 0);
        draw_card(ok, v);
        if (!ok) return;
        ps += v; pc++;
        chk("init_pscore", player_score, ps);
        chk("init_pcards", player_cards, pc);
        draw_card(ok, v);
        if (!ok) return;
        ds += v; dc++;
        chk("play_dscore", dealer_score, ds);
        chk("play_busy", busy, 1);
        chk("play_valid", result_valid, 0);
        for (int k = 0; k < 16; k++) begin
            if (acts_q.size() > 0) begin
                act = acts_q.pop_front();
            end else begin
                r = int'($urandom_range(0, 10));
                act = (r < 5) ? 0 : (r < 9) ? 1 : (r == 9) ? 2 : 3;
            end
            if (act == 3) begin
                start = 1; tick(); start = 0;
                chk("start_in_play_pip", pip, 0);
                chk("start_in_play_busy", busy, 1);
            end else if (act == 0) begin
                hit = 1; tick(); hit = 0;
                draw_card(ok, v);
                if (!ok) return;
                ps += v; pc++;
                chk("hit_pscore", player_score, ps);
                chk("hit_pcards", player_cards, pc);
                if (ps > 21) begin finish_chk(2); return; end
                if (pc == 5) begin finish_chk(1); return; end
                chk("hit_busy", busy, 1);
                chk("hit_valid", result_valid, 0);
            end else begin
                stand = 1; hit = (act == 2); tick(); stand = 0; hit = 0;
                chk("deal_no_pip", pip, 0);
                chk("deal_busy", busy, 1);
                break;
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (ds < 16) begin
                tick();
                draw_card(ok, v);
                if (!ok) return;
                ds += v; dc++;
                chk("dealer_dscore", dealer_score, ds);
                if (ds > 21) begin finish_chk(1); return; end
                if (dc == 5) begin finish_chk(2); return; end
                chk("dealer_busy", busy, 1);
            end else begin
                tick();
                chk("final_no_pip", pip, 0);
                finish_chk(ps > ds ? 1 : (ps < ds ? 2 : 3));
                return;
            end
        end
    endtask

    initial begin
        rst_n = 0;
        tick(); tick();
        chk("rst_pip", pip, 0);
        chk("rst_pscore", player_score, 0);
        chk("rst_dscore", dealer_score, 0);
        chk("rst_pcards", player_cards, 0);
        chk("rst_dcards", dealer_cards, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_empty", deck_empty, 0);
        rst_n = 1;
        tick();

        push_card(10); push_card(10); acts_q.push_back(1);
        round(); tick();
        chk("result_held", result, 3);

        push_card(8); push_card(2); push_card(2); push_card(2);
        acts_q.push_back(0); acts_q.push_back(0);
        round(); tick();

        push_card(1); push_card(5); push_card(1); push_card(11); push_card(12); push_card(13);
        for (int i = 0; i < 4; i++) acts_q.push_back(0);
        round(); tick();

        push_card(9); push_card(3); push_card(5); acts_q.push_back(1);
        round(); tick();

        push_card(2); push_card(6); push_card(6); acts_q.push_back(1);
        round(); tick();

        push_card(10); push_card(10); acts_q.push_back(3); acts_q.push_back(2);
        round(); tick();

        for (int rr = 0; rr < 40 && !m_empty; rr++) begin
            for (int i = 0; i < 8; i++) push_card(int'($urandom_range(0, 15)));
            round();
            repeat (int'($urandom_range(1, 3))) tick();
        end
        chk("deck_empty_sticky", deck_empty, 1);
        start = 1; tick(); start = 0;
        chk("start_ignored_pip", pip, 0);
        chk("start_ignored_busy", busy, 0);
        chk("start_ignored_result", result, 0);
        tick();
        chk("start_ignored_pip2", pip, 0);

        rst_n = 0; tick(); rst_n = 1;
        chk("rst2_empty", deck_empty, 0);
        chk("rst2_valid", result_valid, 0);
        deck_q.delete(); m_deck.delete(); acts_q.delete();
        m_consumed = 0; m_empty = 0;
        tick();
        push_card(7); push_card(4); push_card(3); acts_q.push_back(1);
        round(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ten_half_ctrl.md
# ten_half_ctrl

Round sequencer for the ten-point-half card game. It drives the deck look-up table through its single-cycle `pip` draw strobe and captures the card `number` returned one cycle later. It accumulates player and dealer scores in half-point units, handles the player's hit/stand inputs, auto-plays the dealer, and reports the round outcome. It sits between the button/debounce logic and the deck LUT, and feeds the score/result display.

## Interface

Parameters:
- `DEALER_STAND`, 16: dealer stops drawing when its score is ≥ this value, in half-points (16 = 8 points).
- `MAX_CARDS`, 5: a hand reaching this many cards without busting wins immediately.
- `DECK_SIZE`, 52: total draws available between resets. Must be ≤ 63.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin a round; sampled in IDLE/DONE only.
- `hit` in 1: player draws a card; sampled in PLAY only.
- `stand` in 1: player ends turn; sampled in PLAY only.
- `pip` out 1: draw strobe to the deck LUT.
- `number` in 4: card from the deck LUT, valid the cycle after `pip`.
- `player_score` out 6: player total, half-points.
- `dealer_score` out 6: dealer total, half-points.
- `player_cards` out 3: cards in the player hand.
- `dealer_cards` out 3: cards in the dealer hand.
- `busy` out 1: round in progress.
- `result_valid` out 1: outcome available.
- `result` out 2: outcome code. 00 = abort (deck exhausted), 01 = player wins, 10 = dealer wins, 11 = tie.
- `deck_empty` out 1: sticky; `DECK_SIZE` draws have been consumed.

## Operation

- All outputs reset to 0. The FSM resets to IDLE and the draw counter `deck_cnt` resets to 0. Reset mid-round abandons the round; the deck LUT resets on the same `rst_n`.
- Card value in half-points: `number` 1–10 gives 2×`number`; 11–13 gives 1; 0 and 14–15 give 0. Every card, including a 0-value card, increments the card count.
- Bust: score > 21 half-points (10.5).
- FSM states: IDLE, DRAW, LOAD, PLAY, DEAL, DONE. A `target` register selects player or dealer; a `ret` register selects the state after LOAD.
- IDLE/DONE, on `start` with `deck_empty`=0:
  - Clear both scores, both card counts and `result_valid`.
  - Draw once for the player, then once for the dealer, then enter PLAY.
  - `start` is ignored while `deck_empty`=1 or `busy`=1.
- DRAW:
  - If `deck_cnt` = `DECK_SIZE`: set `deck_empty`=1, `result`=00, `result_valid`=1, and go to DONE. No `pip` is issued.
  - Otherwise: `pip`=1 for this cycle only, `deck_cnt`+1, go to LOAD.
- LOAD:
  - Add the card value to the target score and increment the target card count.
  - After a player hit: bust → DONE with result 10. Card count = `MAX_CARDS` → DONE with result 01. Otherwise → PLAY.
  - After a dealer draw in the dealer phase: bust → DONE with result 01. Card count = `MAX_CARDS` → DONE with result 10. Otherwise → DEAL.
  - The initial two deals cannot bust, since the maximum card value is 20 half-points.
- PLAY:
  - `stand` → DEAL. `stand` wins if `hit` and `stand` are asserted in the same cycle.
  - `hit` → DRAW for the player.
- DEAL:
  - `dealer_score` < `DEALER_STAND` → DRAW for the dealer.
  - Otherwise compare scores: player higher → 01, dealer higher → 10, equal → 11. Then go to DONE.
- `busy` = 1 in DRAW, LOAD, PLAY and DEAL.
- `result_valid` = 1 in DONE. `result` holds its value until the next accepted `start` or reset.
- All arithmetic is unsigned 6-bit. Maximum reachable score is 41 half-points, so no overflow.

## Timing

- All outputs are registered.
- `pip` is high exactly during DRAW cycles and is never high on consecutive cycles.
- `start` sampled in cycle 0 produces:
  - DRAW in cycle 1 (`pip`=1) and LOAD in cycle 2.
  - `player_score` updated in cycle 3.
  - DRAW in cycle 3 and LOAD in cycle 4.
  - `dealer_score` updated and PLAY entered in cycle 5.
- `hit` in PLAY at cycle n: `pip` in cycle n+1, score update visible in cycle n+3. That is also the cycle in which PLAY resumes or `result_valid` rises.
- `stand` at cycle n: DEAL in cycle n+1. If the dealer does not draw, `result_valid`=1 in cycle n+2. Each dealer draw adds 3 cycles (DRAW, LOAD, DEAL).
- `hit`/`stand` are level-sampled once per PLAY cycle. The upstream logic supplies single-cycle pulses.

## Test plan

The bench deck model returns scripted `number` values one cycle after `pip`.

- Reset, then `start` with script 10,10:
  - All outputs are 0 before `start`.
  - `pip` is high in cycles 1 and 3; PLAY is entered in cycle 5 with scores 20/20.
  - `stand` gives `result`=11 two cycles later, with no further `pip`.
- Script 8,2,2,2; `start`, `hit`, `hit`:
  - `player_score` goes 16 → 20 → 24.
  - The second hit ends the round with `result`=10, `busy`=0.
- Script 1,5,1,11,12,13; `start` then four `hit`s:
  - `player_cards`=5, `player_score`=7.
  - `result`=01, with no bust despite MAX_CARDS.
- Script 9,3,5; `start`, `stand`:
  - The dealer draws once (6 → 16) and stops.
  - Result 01, 18 > 16.
- Script 2,6,6; `start`, `stand`: dealer 12 → 24 busts, `result`=01.
- Simultaneous `hit`+`stand` in PLAY: treated as `stand` (no `pip`).
- With `DECK_SIZE`=4, script 10,10,10,10:
  - Round 1 (`stand`) gives tie.
  - Round 2 consumes cards 3–4, then `hit`: no `pip`, `result`=00, `deck_empty`=1.
  - A later `start` is ignored.
  - `rst_n` low clears `deck_empty`.
